// File: rtl/dm_pkg.sv
// Shared data-memory definitions: store type codes used by the store buffer
// and the load-extend codes used by the load side of the MEM stage.
package dm_pkg;

    // Store request encodings presented by the MEM stage
    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SB  = 2'b01,
        ST_SH  = 2'b10,
        ST_RSV = 2'b11
    } st_type_e;

    // Load-extend encodings consumed by the load extender
    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_type_e;

    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

endpackage : dm_pkg

// File: rtl/dm_store_buffer_if.sv
// Bus bundle between the MEM stage / data memory (master side) and the
// store buffer (slave side).
//
// Handshakes:
//  - store side: a store transfers on a cycle where st_valid & st_ready and
//    the request is not misaligned; while st_ready is low the master must hold
//    its request unchanged and the buffer ignores it.
//  - memory side: the head entry transfers on a cycle where dm_req & dm_ack;
//    dm_addr/dm_wdata/dm_be are held stable while dm_req & ~dm_ack, and
//    dm_ack without dm_req has no effect.
interface dm_store_buffer_if #(
    parameter int AW = 32
);
    logic          st_valid;
    logic [1:0]    st_type;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic          st_ready;
    logic          st_misalign;
    logic          dm_req;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic [3:0]    dm_be;
    logic          dm_ack;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic          sb_empty;

    modport master (
        output st_valid, st_type, st_addr, st_data, dm_ack, ld_addr,
        input  st_ready, st_misalign, dm_req, dm_addr, dm_wdata, dm_be,
               ld_hit, sb_empty
    );

    modport slave (
        input  st_valid, st_type, st_addr, st_data, dm_ack, ld_addr,
        output st_ready, st_misalign, dm_req, dm_addr, dm_wdata, dm_be,
               ld_hit, sb_empty
    );
endinterface : dm_store_buffer_if

// File: rtl/store_align.sv
// Combinational store lane aligner: replicates the source data onto every
// lane it could land on and derives byte enables plus a misalignment flag.
module store_align
    import dm_pkg::*;
(
    input  logic [1:0]  st_type_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic        mis_o
);

    // Decode store type and low address bits into lane data/enables
    always_comb begin
        wdata_o = data_i;
        be_o    = 4'b1111;
        mis_o   = 1'b0;
        case (st_type_i)
            ST_SW: begin
                wdata_o = data_i;
                be_o    = 4'b1111;
                mis_o   = |addr_lo_i;
            end
            ST_SH: begin
                wdata_o = {2{data_i[15:0]}};
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                mis_o   = addr_lo_i[0];
            end
            ST_SB: begin
                wdata_o = {4{data_i[7:0]}};
                be_o    = 4'b0001 << addr_lo_i;
                mis_o   = 1'b0;
            end
            default: begin
                // Reserved encoding is never accepted
                wdata_o = data_i;
                be_o    = 4'b0000;
                mis_o   = 1'b1;
            end
        endcase
    end

endmodule : store_align

// File: rtl/dm_store_buffer.sv
// Store buffer between the MEM stage and data memory: aligns stores onto
// byte lanes, rejects misaligned ones, queues accepted stores in a FIFO,
// drains them over req/ack and flags loads that hit a pending store.
module dm_store_buffer
    import dm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    dm_store_buffer_if.slave   bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // FIFO bookkeeping
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          mis_q, mis_d;

    // Entry storage: word address, lane-aligned data, byte enables
    logic [AW-3:0]     addr_q  [DEPTH];
    logic [DATA_W-1:0] wdata_q [DEPTH];
    logic [BE_W-1:0]   be_q    [DEPTH];

    logic [DATA_W-1:0] al_wdata;
    logic [BE_W-1:0]   al_be;
    logic              al_mis;
    logic              push, pop, st_ready, dm_req, hit;
    logic              unused_ld_lsb;

    store_align u_align (
        .st_type_i (bus.st_type),
        .addr_lo_i (bus.st_addr[1:0]),
        .data_i    (bus.st_data),
        .wdata_o   (al_wdata),
        .be_o      (al_be),
        .mis_o     (al_mis)
    );

    // Ready never looks at a same-cycle pop, so a full buffer always stalls
    assign st_ready = (count_q != CW'(DEPTH));
    assign dm_req   = (count_q != '0);
    assign push     = bus.st_valid & st_ready & ~al_mis;
    assign pop      = dm_req & bus.dm_ack;

    // Next-state for pointers, occupancy and the misalign pulse
    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
        mis_d   = bus.st_valid & st_ready & al_mis;
    end

    // Control state with immediate reset (drops any in-flight entry)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mis_q   <= mis_d;
        end
    end

    // Entry write at the tail; contents only matter while counted as valid
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q]  <= bus.st_addr[AW-1:2];
            wdata_q[tail_q] <= al_wdata;
            be_q[tail_q]    <= al_be;
        end
    end

    // Word-address match against every valid entry (byte enables ignored)
    always_comb begin
        logic [PW-1:0] ofs;
        hit = 1'b0;
        ofs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ofs = PW'(i) - head_q;
            if (({1'b0, ofs} < count_q) && (addr_q[i] == bus.ld_addr[AW-1:2])) begin
                hit = 1'b1;
            end
        end
    end

    // The load match is word-granular, so the byte offset is not needed
    assign unused_ld_lsb = ^bus.ld_addr[1:0];

    assign bus.st_ready    = st_ready;
    assign bus.st_misalign = mis_q;
    assign bus.dm_req      = dm_req;
    assign bus.dm_addr     = dm_req ? {addr_q[head_q], 2'b00} : '0;
    assign bus.dm_wdata    = dm_req ? wdata_q[head_q] : '0;
    assign bus.dm_be       = dm_req ? be_q[head_q] : '0;
    assign bus.ld_hit      = hit;
    assign bus.sb_empty    = ~dm_req;

endmodule : dm_store_buffer

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer with hand-computed expectations.
module tb_dm_store_buffer;
    import dm_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [31:0] exp_q[$];

    dm_store_buffer_if #(.AW(32)) sbif ();

    dm_store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sbif.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        sbif.st_valid = 1'b1;
        sbif.st_type  = t;
        sbif.st_addr  = a;
        sbif.st_data  = d;
    endtask

    task automatic idle_st();
        sbif.st_valid = 1'b0;
        sbif.st_type  = ST_SW;
        sbif.st_addr  = '0;
        sbif.st_data  = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_st();
        sbif.dm_ack  = 1'b0;
        sbif.ld_addr = 32'h0;
        rst = 1'b1;
        #12;
        // Reset state
        check("rst_dm_req",   32'(sbif.dm_req), 32'd0);
        check("rst_mis",      32'(sbif.st_misalign), 32'd0);
        check("rst_empty",    32'(sbif.sb_empty), 32'd1);
        check("rst_ready",    32'(sbif.st_ready), 32'd1);
        check("rst_addr",     sbif.dm_addr, 32'h0);
        check("rst_wdata",    sbif.dm_wdata, 32'h0);
        check("rst_be",       32'(sbif.dm_be), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1: sb to 0x103 with ack held high
        sbif.dm_ack = 1'b1;
        drive_st(ST_SB, 32'h103, 32'h0000_00A5);
        step();
        idle_st();
        check("t1_req",   32'(sbif.dm_req), 32'd1);
        check("t1_addr",  sbif.dm_addr, 32'h100);
        check("t1_wdata", sbif.dm_wdata, 32'hA5A5_A5A5);
        check("t1_be",    32'(sbif.dm_be), 32'b1000);
        step();
        check("t1_empty", 32'(sbif.sb_empty), 32'd1);
        sbif.dm_ack = 1'b0;

        // 2: sh then sw, FIFO order
        drive_st(ST_SH, 32'h202, 32'h0000_1234);
        step();
        drive_st(ST_SW, 32'h204, 32'hDEAD_BEEF);
        step();
        idle_st();
        check("t2_b0_addr",  sbif.dm_addr, 32'h200);
        check("t2_b0_be",    32'(sbif.dm_be), 32'b1100);
        check("t2_b0_wdata", sbif.dm_wdata, 32'h1234_1234);
        sbif.dm_ack = 1'b1;
        step();
        check("t2_b1_addr",  sbif.dm_addr, 32'h204);
        check("t2_b1_be",    32'(sbif.dm_be), 32'b1111);
        check("t2_b1_wdata", sbif.dm_wdata, 32'hDEAD_BEEF);
        step();
        check("t2_empty", 32'(sbif.sb_empty), 32'd1);
        sbif.dm_ack = 1'b0;

        // 3: misaligned / reserved stores
        drive_st(ST_SW, 32'h0001, 32'h1111_1111);
        step();
        check("t3_sw_mis", 32'(sbif.st_misalign), 32'd1);
        check("t3_sw_empty", 32'(sbif.sb_empty), 32'd1);
        drive_st(ST_SH, 32'h0003, 32'h2222_2222);
        step();
        check("t3_sh_mis", 32'(sbif.st_misalign), 32'd1);
        check("t3_sh_req", 32'(sbif.dm_req), 32'd0);
        drive_st(ST_RSV, 32'h0000, 32'h3333_3333);
        step();
        check("t3_rsv_mis", 32'(sbif.st_misalign), 32'd1);
        check("t3_rsv_empty", 32'(sbif.sb_empty), 32'd1);
        idle_st();
        step();
        check("t3_mis_clear", 32'(sbif.st_misalign), 32'd0);
        check("t3_req", 32'(sbif.dm_req), 32'd0);

        // 4: fill to DEPTH, a 5th request is ignored (no misalign check either)
        for (int i = 0; i < 4; i++) begin
            drive_st(ST_SW, 32'h400 + 32'(4 * i), 32'(i + 1));
            step();
        end
        check("t4_full_ready", 32'(sbif.st_ready), 32'd0);
        drive_st(ST_SW, 32'h501, 32'h5555_5555);
        step();
        check("t4_ignored_ready", 32'(sbif.st_ready), 32'd0);
        check("t4_ignored_mis", 32'(sbif.st_misalign), 32'd0);
        check("t4_head_stable", sbif.dm_addr, 32'h400);
        idle_st();
        sbif.dm_ack = 1'b1;
        step();
        sbif.dm_ack = 1'b0;
        check("t4_ready_after_ack", 32'(sbif.st_ready), 32'd1);
        check("t4_head1_addr", sbif.dm_addr, 32'h404);
        step();
        check("t4_head1_hold", sbif.dm_wdata, 32'd2);
        sbif.dm_ack = 1'b1;
        step();
        check("t4_head2_addr", sbif.dm_addr, 32'h408);
        step();
        check("t4_head3_addr", sbif.dm_addr, 32'h40C);
        step();
        check("t4_empty", 32'(sbif.sb_empty), 32'd1);
        sbif.dm_ack = 1'b0;

        // 5: two entries resident, push+ack together for 6 cycles
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            drive_st(ST_SW, 32'h600 + 32'(4 * i), 32'h600 + 32'(4 * i));
            exp_q.push_back(32'h600 + 32'(4 * i));
            step();
        end
        sbif.dm_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("t5_head_addr", sbif.dm_addr, exp_q[0]);
            check("t5_head_data", sbif.dm_wdata, exp_q[0]);
            drive_st(ST_SW, 32'h608 + 32'(4 * k), 32'h608 + 32'(4 * k));
            exp_q.push_back(32'h608 + 32'(4 * k));
            step();
            void'(exp_q.pop_front());
            check("t5_ready", 32'(sbif.st_ready), 32'd1);
        end
        idle_st();
        for (int k = 0; k < 2; k++) begin
            check("t5_drain_addr", sbif.dm_addr, exp_q[0]);
            void'(exp_q.pop_front());
            step();
        end
        check("t5_empty", 32'(sbif.sb_empty), 32'd1);
        sbif.dm_ack = 1'b0;

        // 6: load hazard compare, then reset mid-drain
        drive_st(ST_SW, 32'h300, 32'hCAFE_F00D);
        step();
        idle_st();
        sbif.ld_addr = 32'h302;
        #1;
        check("t6_hit_same_word", 32'(sbif.ld_hit), 32'd1);
        sbif.ld_addr = 32'h304;
        #1;
        check("t6_miss_next_word", 32'(sbif.ld_hit), 32'd0);
        drive_st(ST_SW, 32'h304, 32'h0);
        #1;
        check("t6_push_ignored", 32'(sbif.ld_hit), 32'd0);
        step();
        idle_st();
        check("t6_hit_after_push", 32'(sbif.ld_hit), 32'd1);
        check("t6_req", 32'(sbif.dm_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_req", 32'(sbif.dm_req), 32'd0);
        check("t6_rst_empty", 32'(sbif.sb_empty), 32'd1);
        check("t6_rst_hit", 32'(sbif.ld_hit), 32'd0);
        check("t6_rst_ready", 32'(sbif.st_ready), 32'd1);
        step();
        rst = 1'b0;
        step();
        check("t6_post_rst_empty", 32'(sbif.sb_empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dm_store_buffer
